hilo_muldiv: RTL
================

# hilo_muldiv

Sequential multiply/divide unit that owns the architectural HI/LO register pair. It sits directly downstream of the execute-stage ALU operand path. It takes the same A/B operands and computes MULT/MULTU/DIV/DIVU iteratively over 33 cycles. It also services MTHI/MTLO writes and drives HI/LO continuously for MFHI/MFLO.

## Interface
- Parameters: none; datapath fixed at 32 bits.
- `clk` input 1: single clock, rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request strobe, sampled on rising edge.
- `op` input 2: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- `is_signed` input 1: 1 selects two's-complement MULT/DIV; 0 selects unsigned; ignored for MTHI/MTLO.
- `a` input 32: multiplicand / dividend / MTHI-MTLO source.
- `b` input 32: multiplier / divisor.
- `hi` output 32: HI register (product upper word / remainder).
- `lo` output 32: LO register (product lower word / quotient).
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse when new MULT/DIV result is visible on `hi`/`lo`.
- `div_zero` output 1: last completed DIV had `b`==0.

## Operation
- Reset (async, `reset_n`=0): `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, FSM in IDLE, iteration counter 0.
- FSM states:
  - IDLE: accepts `start`.
    - MULT/DIV → RUN. Latch operand magnitudes (`|a|`,`|b|` when signed, raw otherwise), sign bits, op; counter=0.
    - MTHI/MTLO → write `a` into `hi`/`lo` at that edge; stay IDLE; no `busy`, no `done`.
  - RUN: one radix-2 step per cycle for 32 cycles.
    - Multiply: shift-add into a 64-bit accumulator.
    - Divide: restoring shift-subtract producing 32-bit quotient and remainder.
    - After step 31 → FIX.
  - FIX: sign correction and HI/LO write; → IDLE.
    - Multiply: negate 64-bit product if signed and sign(a)^sign(b). HI=upper 32 bits, LO=lower 32 bits.
    - Divide: negate quotient if signed and sign(a)^sign(b). Remainder takes the sign of the dividend (truncating division). LO=quotient, HI=remainder.
    - Divide by zero: LO=0xFFFFFFFF, HI=raw `a`, `div_zero`=1, sign correction bypassed.
    - Any other completed DIV clears `div_zero`. MULT leaves `div_zero` unchanged.
    - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no flag.
- `start` while `busy`=1 is ignored for every op, including MTHI/MTLO. No queuing.
- `a`/`b`/`is_signed`/`op` need only be valid at the accepting edge.
- `hi`/`lo` hold their old values throughout RUN. No partial results are exposed.

## Timing
- E0 = accepting edge of a MULT/DIV `start`.
- `busy`=1 from after E0 through the cycle ending at E33.
- RUN occupies E1..E32; FIX is written at E33.
- After E33: `hi`/`lo` hold the result, `busy`=0, `done`=1 for exactly that one cycle.
- Fixed latency of 33 cycles for every MULT/DIV, including divide-by-zero.
- A new `start` is accepted at E33 itself? No. The earliest accept is the edge after E33, i.e. when `busy` is observed 0.
- MTHI/MTLO: `hi`/`lo` update at the accepting edge; visible the following cycle.
- Reset asserted mid-operation aborts immediately. All outputs return to reset values, and the partial result is discarded.

## Configuration
- `HILO_MULDIV_DIV_EN` defined: divider datapath compiled in; DIV behaves as above.
- `HILO_MULDIV_DIV_EN` undefined: divider logic omitted.
  - `start` with `op`=01 is accepted but skips RUN/FIX.
  - `busy` stays 0 and `done` pulses in the cycle after E0.
  - `hi`/`lo` are unchanged and `div_zero` stays 0.
  - MULT/MTHI/MTLO are unaffected.

## Test plan
- Unsigned MULT 0xFFFFFFFF×0xFFFFFFFF → `busy` high 33 cycles, then `done`=1 with HI=0xFFFFFFFE, LO=0x00000001.
- Signed MULT a=0xFFFFFFFD (−3), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; unsigned same operands → HI=0x00000004, LO=0xFFFFFFF1.
- Signed DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, `div_zero`=0; signed 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV 10/0 → LO=0xFFFFFFFF, HI=0x0000000A, `div_zero`=1; a following DIV 9/3 clears it (LO=3, HI=0).
- MTLO 0x12345678 while idle → LO=0x12345678 next cycle, no `done`; MTHI issued during a running MULT → ignored; HI becomes the product at E33.
- Reset pulse at cycle 10 of a MULT → immediately HI=LO=0, `busy`=0, no `done`; the next MULT completes normally in 33 cycles.

Source files
------------

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative 32-bit MULT/DIV unit owning the HI/LO register pair (33-cycle fixed latency).
// Build option HILO_MULDIV_DIV_EN compiles in the restoring divider; without it DIV completes as a no-op.
module hilo_muldiv (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);
    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_acc_hi, r_acc_lo, r_opnd;
    logic [31:0] w_acc_hi_nxt, w_acc_lo_nxt, w_opnd_nxt;
    logic        r_sign_a, r_sign_b, w_sign_a_nxt, w_sign_b_nxt;
    logic [31:0] r_hi, r_lo, w_hi_nxt, w_lo_nxt;
    logic        r_busy, r_done, r_div_zero;
    logic        w_busy_nxt, w_done_nxt, w_div_zero_nxt;
    logic        w_accept, w_go_run;
    logic [31:0] w_abs_a, w_abs_b;
    logic [32:0] w_mul_sum;
    logic [31:0] w_mul_lo;
    logic [63:0] w_prod_fix;
`ifdef HILO_MULDIV_DIV_EN
    logic        r_is_div, w_is_div_nxt;
    logic [31:0] r_a_raw, w_a_raw_nxt;
    logic [32:0] w_div_shift;
    logic        w_div_ge;
    logic [31:0] w_div_sub, w_quo_fix, w_rem_fix;
`endif

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    assign w_accept   = start && (r_state == S_IDLE);
    assign w_abs_a    = (is_signed && a[31]) ? neg32(a) : a;
    assign w_abs_b    = (is_signed && b[31]) ? neg32(b) : b;
    // Multiply keeps {partial product, remaining multiplier bits} in acc_hi:acc_lo.
    assign w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_mul_lo   = {w_mul_sum[0], r_acc_lo[31:1]};
    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? (~{r_acc_hi, r_acc_lo} + 64'd1) : {r_acc_hi, r_acc_lo};
`ifdef HILO_MULDIV_DIV_EN
    assign w_go_run    = w_accept && ((op == OP_MULT) || (op == OP_DIV));
    assign w_div_shift = {r_acc_hi, r_acc_lo[31]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_sub   = w_div_shift[31:0] - r_opnd;
    assign w_quo_fix   = (r_sign_a ^ r_sign_b) ? neg32(r_acc_lo) : r_acc_lo;
    assign w_rem_fix   = r_sign_a ? neg32(r_acc_hi) : r_acc_hi;
`else
    assign w_go_run    = w_accept && (op == OP_MULT);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go_run) w_state_nxt = S_RUN;
                else          w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (r_cnt == 5'd31) w_state_nxt = S_FIX;
                else                w_state_nxt = S_RUN;
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_acc_hi_nxt = r_acc_hi;
        w_acc_lo_nxt = r_acc_lo;
        w_opnd_nxt   = r_opnd;
        w_sign_a_nxt = r_sign_a;
        w_sign_b_nxt = r_sign_b;
`ifdef HILO_MULDIV_DIV_EN
        w_is_div_nxt = r_is_div;
        w_a_raw_nxt  = r_a_raw;
`endif
        if (w_go_run) begin
            w_cnt_nxt    = 5'd0;
            w_acc_hi_nxt = 32'd0;
            w_sign_a_nxt = is_signed & a[31];
            w_sign_b_nxt = is_signed & b[31];
            if (op == OP_MULT) begin
                w_acc_lo_nxt = w_abs_b;
                w_opnd_nxt   = w_abs_a;
            end else begin
                w_acc_lo_nxt = w_abs_a;
                w_opnd_nxt   = w_abs_b;
            end
`ifdef HILO_MULDIV_DIV_EN
            w_is_div_nxt = (op == OP_DIV);
            w_a_raw_nxt  = a;
`endif
        end else if (r_state == S_RUN) begin
            w_cnt_nxt = r_cnt + 5'd1;
`ifdef HILO_MULDIV_DIV_EN
            if (r_is_div) begin
                w_acc_hi_nxt = w_div_ge ? w_div_sub : w_div_shift[31:0];
                w_acc_lo_nxt = {r_acc_lo[30:0], w_div_ge};
            end else begin
                w_acc_hi_nxt = w_mul_sum[32:1];
                w_acc_lo_nxt = w_mul_lo;
            end
`else
            w_acc_hi_nxt = w_mul_sum[32:1];
            w_acc_lo_nxt = w_mul_lo;
`endif
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // HI/LO change only on MTHI/MTLO in IDLE or at FIX, so no partial result is ever visible.
    always_comb begin
        w_hi_nxt       = r_hi;
        w_lo_nxt       = r_lo;
        w_done_nxt     = 1'b0;
        w_div_zero_nxt = r_div_zero;
        w_busy_nxt     = (w_state_nxt != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_accept && (op == OP_MTHI)) w_hi_nxt = a;
                else if (w_accept && (op == OP_MTLO)) w_lo_nxt = a;
`ifndef HILO_MULDIV_DIV_EN
                else if (w_accept && (op == OP_DIV)) w_done_nxt = 1'b1;
`endif
                else w_done_nxt = 1'b0;
            end
            S_RUN: w_done_nxt = 1'b0;
            S_FIX: begin
                w_done_nxt = 1'b1;
`ifdef HILO_MULDIV_DIV_EN
                if (r_is_div && (r_opnd == 32'd0)) begin
                    w_hi_nxt       = r_a_raw;
                    w_lo_nxt       = 32'hFFFF_FFFF;
                    w_div_zero_nxt = 1'b1;
                end else if (r_is_div) begin
                    w_hi_nxt       = w_rem_fix;
                    w_lo_nxt       = w_quo_fix;
                    w_div_zero_nxt = 1'b0;
                end else begin
                    w_hi_nxt = w_prod_fix[63:32];
                    w_lo_nxt = w_prod_fix[31:0];
                end
`else
                w_hi_nxt = w_prod_fix[63:32];
                w_lo_nxt = w_prod_fix[31:0];
`endif
            end
            default: w_done_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= 5'd0;
            r_acc_hi   <= 32'd0;
            r_acc_lo   <= 32'd0;
            r_opnd     <= 32'd0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
`ifdef HILO_MULDIV_DIV_EN
            r_is_div   <= 1'b0;
            r_a_raw    <= 32'd0;
`endif
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_acc_hi   <= w_acc_hi_nxt;
            r_acc_lo   <= w_acc_lo_nxt;
            r_opnd     <= w_opnd_nxt;
            r_sign_a   <= w_sign_a_nxt;
            r_sign_b   <= w_sign_b_nxt;
            r_hi       <= w_hi_nxt;
            r_lo       <= w_lo_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_div_zero <= w_div_zero_nxt;
`ifdef HILO_MULDIV_DIV_EN
            r_is_div   <= w_is_div_nxt;
            r_a_raw    <= w_a_raw_nxt;
`endif
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
endmodule
